// File: rtl/count_tracker.sv
// Passive checker for a wrapping enable-gated up-counter: syncs on START, flags first illegal step (sticky), counts wraps.
// All outputs registered, one cycle after the sampled x; observe-only, no flow control or backpressure.
module count_tracker #(
    parameter int W     = 4,
    parameter int START = 1,
    parameter int KMAX  = 2**W-1,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  x,
    output logic          sync_ok,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [W-1:0]  exp_x,
    output logic [CW-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [W-1:0]  START_V  = W'(START);
    localparam logic [W-1:0]  KMAX_V   = W'(KMAX);
    localparam logic [W-1:0]  ONE_W    = W'(1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] WRAP_MAX = '1;

    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_STALL   = 2'd2;
    localparam logic [1:0] CODE_STEP    = 2'd3;

    state_t        state_q, state_d;
    logic          sync_ok_q, sync_ok_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [W-1:0]  exp_x_q, exp_x_d;
    logic [CW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [W-1:0]  prev_x_q, prev_x_d;
    logic          prev_en_q, prev_en_d;

    logic [W-1:0]  model_x;
    logic          x_legal;
    logic          wrap_hit;

    always_comb begin
        model_x = x;
        if (en) begin
            model_x = (x == KMAX_V) ? START_V : x + ONE_W;
        end
        x_legal  = (x >= START_V) && (x <= KMAX_V);
        wrap_hit = (prev_x_q == KMAX_V) && prev_en_q && (x == START_V);
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        exp_x_d    = exp_x_q;
        wrap_cnt_d = wrap_cnt_q;
        prev_x_d   = x;
        prev_en_d  = en;

        case (state_q)
            ST_TRACK: begin
                // Priority: illegal value beats stall beats step mismatch.
                if (!x_legal) begin
                    state_d    = ST_ERROR;
                    err_code_d = CODE_ILLEGAL;
                end else if (!prev_en_q && (x != prev_x_q)) begin
                    state_d    = ST_ERROR;
                    err_code_d = CODE_STALL;
                end else if (x != exp_x_q) begin
                    state_d    = ST_ERROR;
                    err_code_d = CODE_STEP;
                end else begin
                    exp_x_d = model_x;
                    if (wrap_hit && (wrap_cnt_q != WRAP_MAX)) begin
                        wrap_cnt_d = wrap_cnt_q + ONE_C;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                // Unused encoding shares UNSYNC behaviour so it self-recovers.
                state_d = ST_UNSYNC;
                if (x == START_V) begin
                    state_d = ST_TRACK;
                    exp_x_d = model_x;
                end
            end
        endcase

        sync_ok_d = (state_d == ST_TRACK);
        err_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UNSYNC;
            sync_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            exp_x_q    <= START_V;
            wrap_cnt_q <= '0;
            prev_x_q   <= START_V;
            prev_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_ok_q  <= sync_ok_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            exp_x_q    <= exp_x_d;
            wrap_cnt_q <= wrap_cnt_d;
            prev_x_q   <= prev_x_d;
            prev_en_q  <= prev_en_d;
        end
    end

    assign sync_ok  = sync_ok_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign exp_x    = exp_x_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: directed scenarios plus randomized counter traffic against a behavioural model.
module tb_count_tracker;

    localparam int W     = 4;
    localparam int START = 1;
    localparam int KMAX  = 15;
    localparam int CW    = 2;
    localparam int SPAN  = KMAX - START + 1;
    localparam int WSAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [W-1:0]  x   = '0;
    logic          sync_ok;
    logic          err;
    logic [1:0]    err_code;
    logic [W-1:0]  exp_x;
    logic [CW-1:0] wrap_cnt;

    int checks = 0;
    int errs   = 0;
    bit chk_en = 1'b0;

    // Behavioural model of what the checker must report.
    int m_synced, m_err, m_code, m_pred, m_wraps, m_prevx, m_preven;

    count_tracker #(.W(W), .START(START), .KMAX(KMAX), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .x        (x),
        .sync_ok  (sync_ok),
        .err      (err),
        .err_code (err_code),
        .exp_x    (exp_x),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    function automatic int predict(input int v, input int e);
        return e ? ((v - START + 1) % SPAN) + START : v;
    endfunction

    function automatic int gnext(input int v);
        return (v >= KMAX) ? START : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        int xi, ei, code;
        xi = int'(x);
        ei = int'(en);
        if (rst) begin
            m_synced = 0; m_err = 0; m_code = 0; m_pred = START; m_wraps = 0;
            m_prevx = START; m_preven = 0;
        end else begin
            if (m_err == 0) begin
                if (m_synced == 0) begin
                    if (xi == START) begin
                        m_synced = 1;
                        m_pred   = predict(xi, ei);
                    end
                end else begin
                    code = 0;
                    if (xi < START || xi > KMAX)               code = 1;
                    else if (m_preven == 0 && xi != m_prevx)   code = 2;
                    else if (xi != m_pred)                     code = 3;
                    if (code != 0) begin
                        m_err = 1; m_code = code; m_synced = 0;
                    end else begin
                        if (m_prevx == KMAX && m_preven == 1 && xi == START && m_wraps < WSAT)
                            m_wraps++;
                        m_pred = predict(xi, ei);
                    end
                end
            end
            m_prevx  = xi;
            m_preven = ei;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sync_ok", 32'(sync_ok), m_synced);
            chk("err", 32'(err), m_err);
            chk("err_code", 32'(err_code), m_code);
            chk("exp_x", 32'(exp_x), m_pred);
            chk("wrap_cnt", 32'(wrap_cnt), m_wraps);
        end
    end

    task automatic step(input int xv, input int ev, input int rv);
        x   = W'(xv);
        en  = ev[0];
        rst = rv[0];
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        step(0, 0, 1);
        step(0, 0, 1);
    endtask

    task automatic run_count(input int first, input int n);
        int v;
        v = first;
        for (int i = 0; i < n; i++) begin
            step(v, 1, 0);
            v = gnext(v);
        end
    endtask

    initial begin
        int gen, xv, ev, rv;
        @(negedge clk);
        do_reset();
        chk("rst_sync_ok", 32'(sync_ok), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_exp_x", 32'(exp_x), START);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
        chk_en = 1'b1;

        // Illegal zeros while unsynced are ignored; START syncs.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            chk("unsync_zero_sync", 32'(sync_ok), 0);
            chk("unsync_zero_err", 32'(err), 0);
        end
        step(1, 1, 0);
        chk("sync_rise", 32'(sync_ok), 1);
        chk("sync_exp_x", 32'(exp_x), 2);

        // 40-cycle clean run with two wraps.
        do_reset();
        run_count(1, 40);
        chk("run40_err", 32'(err), 0);
        chk("run40_wraps", 32'(wrap_cnt), 2);
        chk("run40_exp_x", 32'(exp_x), 11);

        // Stall at 7 then moving to 8.
        do_reset();
        run_count(1, 6);
        step(7, 0, 0);
        chk("stall_hold_err", 32'(err), 0);
        step(8, 1, 0);
        chk("stall_err", 32'(err), 1);
        chk("stall_code", 32'(err_code), 2);
        step(0, 1, 0);
        step(3, 0, 0);
        step(1, 1, 0);
        chk("stall_code_sticky", 32'(err_code), 2);
        chk("stall_sync_ok", 32'(sync_ok), 0);

        // Zero after KMAX is code 1, not 3.
        do_reset();
        run_count(1, 15);
        step(0, 1, 0);
        chk("zero_code", 32'(err_code), 1);

        // KMAX repeated with en=1 is a step violation.
        do_reset();
        run_count(1, 15);
        step(15, 1, 0);
        chk("kmax_repeat_code", 32'(err_code), 3);

        // Legal stall at KMAX, then wrap.
        do_reset();
        run_count(1, 14);
        step(15, 0, 0);
        step(15, 1, 0);
        step(1, 1, 0);
        chk("kmax_stall_err", 32'(err), 0);
        chk("kmax_stall_wrap", 32'(wrap_cnt), 1);

        // Five wraps saturate a 2-bit counter.
        do_reset();
        run_count(1, 5 * 15 + 1);
        chk("sat_wraps", 32'(wrap_cnt), 3);

        // Reset wins over a step violation in the same cycle.
        do_reset();
        run_count(1, 16);
        chk("pre_rst_wraps", 32'(wrap_cnt), 1);
        step(5, 1, 1);
        chk("rst_over_err_err", 32'(err), 0);
        chk("rst_over_err_sync", 32'(sync_ok), 0);
        chk("rst_over_err_wraps", 32'(wrap_cnt), 0);
        step(2, 1, 0);
        chk("resync_needs_start", 32'(sync_ok), 0);

        // Randomized counter traffic with glitches and resets.
        gen = $urandom_range(0, 15);
        for (int i = 0; i < 3000; i++) begin
            rv = (($urandom % 200) == 0 || (m_err != 0 && ($urandom % 10) == 0)) ? 1 : 0;
            ev = (($urandom % 4) != 0) ? 1 : 0;
            xv = gen;
            if (($urandom % 80) == 0) xv = $urandom_range(0, 15);
            step(xv, ev, rv);
            if (rv != 0) gen = $urandom_range(0, 15);
            else if (ev != 0) gen = gnext(gen);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/count_tracker.md
# count_tracker

Cycle-accurate checker that observes a wrapping up-counter (enable-gated, sequence START..KMAX then back to START) and verifies every transition. It sits beside the counter it monitors and has no effect on the counter. It tracks the counter's value and enable each cycle, flags the first illegal step with a sticky error and cause code, and counts completed wraps. `err` is the block's safety output for formal runs (`assert property (!err)`).

## Interface
- `W`, 4, width of the observed counter value
- `START`, 1, counter restart value; must be at least 1
- `KMAX`, 2**W-1, last value before wrap; must exceed START and fit in W bits
- `CW`, 8, width of the wrap counter
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  observed counter enable
- `x`  input  W  observed counter value
- `sync_ok`  output  1  high while in TRACK
- `err`  output  1  sticky error flag
- `err_code`  output  2  cause of first error: 0 none, 1 illegal value, 2 stall violation, 3 step violation
- `exp_x`  output  W  registered prediction of next `x`
- `wrap_cnt`  output  CW  count of observed KMAX->START wraps, saturating

## Operation
- Model: the observed counter obeys `x(t+1) = en(t) ? (x(t)==KMAX ? START : x(t)+1) : x(t)`. All arithmetic is W bits. The wrap is explicit, never a modulo-2^W overflow.
- Legal value: `START <= x <= KMAX`.
- States: UNSYNC, TRACK, ERROR, encoded in 2 bits; the fourth encoding is unreachable and behaves as UNSYNC.
- UNSYNC:
  - Ignores `en`, and ignores illegal values of `x`.
  - When `x == START` is sampled, go to TRACK at that edge.
  - At the same edge, load `exp_x` = model(x, en).
- TRACK: at each edge, check the sampled `x` in priority order:
  - If `x` is illegal, go to ERROR with code 1.
  - Otherwise, if `prev_en == 0` and `x != prev_x`, go to ERROR with code 2.
  - Otherwise, if `x != exp_x`, go to ERROR with code 3.
  - Otherwise stay in TRACK and reload `exp_x` = model(x, en).
- `prev_x` and `prev_en` are registered copies of the previous sample, updated every cycle in every state.
- Wrap count: in TRACK, on a passing check where `prev_x == KMAX`, `prev_en == 1` and `x == START`, increment `wrap_cnt` unless it is already 2**CW-1.
- ERROR:
  - Absorbing until `rst`.
  - `err_code` holds the first cause; `exp_x` and `wrap_cnt` freeze.
  - `sync_ok` is 0.
- `err` is 1 exactly when the state is ERROR.

## Timing
- All outputs are registered; none has a combinational input-to-output path.
- Reset values: state UNSYNC, `sync_ok`=0, `err`=0, `err_code`=0, `exp_x`=START, `wrap_cnt`=0, `prev_x`=START, `prev_en`=0.
- `rst` overrides every other condition, including an error detected in the same cycle.
- Reset asserted mid-TRACK or in ERROR returns the block to UNSYNC on the next edge. Re-sync then requires a fresh `x == START` sample.
- Sync latency: `x == START` sampled at edge t gives `sync_ok`=1 after edge t. The first check happens at edge t+1.
- Error latency: a bad `x` sampled at edge t gives `err`=1 and a valid `err_code` after edge t, one cycle after the bad value appeared on `x`.
- Wrap latency: `wrap_cnt` updates after the edge at which START is sampled following KMAX.
- A stall (`en=0`) at KMAX is legal, and `x` must then hold KMAX. A wrap is legal only from KMAX with `en=1`.
- Value 0 arriving while in TRACK gives code 1 even when a step rule would also be violated.

## Test plan
- Reset, then hold `x`=0 for 3 cycles and present `x`=1: `sync_ok` stays 0 with no error during the 0 cycles, and rises after the edge that samples 1. `exp_x` reads 2 when `en`=1 at that edge.
- Synced counter with `en`=1 for 40 cycles (1..15,1..15,1..10): `err`=0 throughout, `wrap_cnt`=2, `exp_x`=11 at the end.
- Synced counter at `x`=7, `en`=0, then `x` changes to 8: `err`=1, `err_code`=2 after the edge that samples 8. Further stimulus leaves the code at 2.
- Synced at `x`=15, `en`=1, then `x`=0: `err_code`=1, not 3. Separately, `x`=15 with `en`=1 followed by `x`=15: `err_code`=3.
- Run with `CW`=2 through 5 wraps: `wrap_cnt` saturates at 3.
- Assert `rst` in the same cycle a step violation appears: state goes to UNSYNC, `err`=0 and `wrap_cnt`=0 after that edge.
